xalu_ctrl: RTL and testbench

XALU_CTRL -- requirements
Module: xalu_ctrl

---
 rtl/xalu_pkg.sv | 19 +
 rtl/xalu_arith.sv | 59 +++++
 rtl/xalu_ctrl.sv | 105 ++++++++++
 tb/tb_xalu_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// op encodings, FSM state constants and default latencies.
package xalu_pkg;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DIV  = 2'd2;

   localparam int DEF_MUL_LAT = 5;
   localparam int DEF_DIV_LAT = 10;

endpackage

// File: rtl/xalu_arith.sv
// Combinational product / quotient / remainder unit.
// wr is low when a divide has a zero divisor (HI/LO keep their value).
module xalu_arith
   import xalu_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        wr
);

   logic [63:0] sprod;
   logic [63:0] uprod;
   logic        sgn;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] dvsr;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq;
   logic [31:0] sr;

   assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign uprod = {32'd0, a} * {32'd0, b};

   // Signed divide runs on magnitudes; 0x80000000 / -1 wraps to itself.
   assign sgn   = (op == OP_DIV);
   assign mag_a = (sgn && a[31]) ? (32'd0 - a) : a;
   assign mag_b = (sgn && b[31]) ? (32'd0 - b) : b;
   assign dvsr  = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign uq    = mag_a / dvsr;
   assign ur    = mag_a % dvsr;
   assign sq    = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
   assign sr    = (sgn && a[31]) ? (32'd0 - ur) : ur;

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      wr = 1'b1;
      unique case (op)
         OP_MULT: begin
            hi = sprod[63:32];
            lo = sprod[31:0];
         end
         OP_MULTU: begin
            hi = uprod[63:32];
            lo = uprod[31:0];
         end
         default: begin
            hi = sr;
            lo = sq;
            wr = (b != 32'd0);
         end
      endcase
   end

endmodule

// File: rtl/xalu_ctrl.sv
// Multi-cycle MULT/DIV controller owning HI/LO and the busy stall.
// Define XALU_FLUSH_EN to add the flush port that cancels an op.
module xalu_ctrl
   import xalu_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef XALU_FLUSH_EN
   input  logic        flush,
`endif
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        movto,
   input  logic        movto_sel,
   input  logic [31:0] movto_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT) + 1;
   localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_wr;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic          res_wr;
   logic          is_div;
   logic          kill;

`ifdef XALU_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   xalu_arith u_arith (
      .op (op),
      .a  (a),
      .b  (b),
      .hi (res_hi),
      .lo (res_lo),
      .wr (res_wr)
   );

   assign is_div = op[1];
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         done    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !kill) begin
                  pend_hi <= res_hi;
                  pend_lo <= res_lo;
                  pend_wr <= res_wr;
                  cnt     <= is_div ? DIV_CNT : MUL_CNT;
                  state   <= is_div ? ST_DIV : ST_MUL;
               end else if (movto && !start) begin
                  if (movto_sel) hi <= movto_data;
                  else           lo <= movto_data;
               end
            end
            default: begin
               if (kill) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  if (pend_wr) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xalu_ctrl.sv
// Directed bench for xalu_ctrl with a HI/LO scoreboard queue.
// Flush steps are built only when XALU_FLUSH_EN is defined.
module tb_xalu_ctrl;
   import xalu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        movto;
   logic        movto_sel;
   logic [31:0] movto_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef XALU_FLUSH_EN
   logic        flush;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [63:0] sb[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   always #5 clk = ~clk;

   xalu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef XALU_FLUSH_EN
      .flush      (flush),
`endif
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .movto      (movto),
      .movto_sel  (movto_sel),
      .movto_data (movto_data),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mov(input string tag, input logic sel,
                      input logic [31:0] data);
      movto = 1'b1;
      movto_sel = sel;
      movto_data = data;
      tick;
      movto = 1'b0;
      if (sel) m_hi = data;
      else     m_lo = data;
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat, input bit meddle,
                         input bit with_mov);
      logic [63:0] exp;
      sb.push_back({ehi, elo});
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      if (with_mov) begin
         movto = 1'b1;
         movto_sel = 1'b0;
         movto_data = 32'h5555_5555;
      end
      tick;
      start = 1'b0;
      movto = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         chk({tag, "_busy"}, busy, 64'd1);
         chk({tag, "_nodone"}, done, 64'd0);
         chk({tag, "_hold_hi"}, hi, m_hi);
         chk({tag, "_hold_lo"}, lo, m_lo);
         if (meddle && i == 2) begin
            start = 1'b1;
            op = OP_MULT;
            a = 32'd7;
            b = 32'd7;
            movto = 1'b1;
            movto_sel = 1'b1;
            movto_data = 32'hDEAD;
         end
         tick;
         start = 1'b0;
         movto = 1'b0;
      end
      chk({tag, "_idle"}, busy, 64'd0);
      chk({tag, "_done"}, done, 64'd1);
      if (done === 1'b1 && sb.size() > 0) begin
         exp = sb.pop_front();
         chk({tag, "_hi"}, hi, exp[63:32]);
         chk({tag, "_lo"}, lo, exp[31:0]);
         m_hi = exp[63:32];
         m_lo = exp[31:0];
      end
      tick;
      chk({tag, "_pulse"}, done, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op = OP_MULT;
      a = 32'd0;
      b = 32'd0;
      movto = 1'b0;
      movto_sel = 1'b0;
      movto_data = 32'd0;
`ifdef XALU_FLUSH_EN
      flush = 1'b0;
`endif
      #12;
      chk("rst_busy", busy, 64'd0);
      chk("rst_done", done, 64'd0);
      chk("rst_hi", hi, 64'd0);
      chk("rst_lo", lo, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, 0);
      run_op("divu", OP_DIVU, 32'd7, 32'd2,
             32'd1, 32'd3, 10, 0, 0);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, 0);

      mov("mthi", 1'b1, 32'h11);
      mov("mtlo", 1'b0, 32'h22);
      run_op("div0", OP_DIV, 32'd5, 32'd0,
             32'h11, 32'h22, 10, 0, 0);

      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'd0, 32'h8000_0000, 10, 0, 0);
      run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'd0, 5, 0, 0);
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'd1, 5, 0, 0);
      run_op("meddle", OP_DIV, 32'd7, 32'hFFFF_FFFE,
             32'd1, 32'hFFFF_FFFD, 10, 1, 0);
      run_op("start_mov", OP_MULTU, 32'd2, 32'd3,
             32'd0, 32'd6, 5, 0, 1);
      run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10,
             32'hF, 32'h0FFF_FFFF, 10, 0, 0);
      mov("mthi2", 1'b1, 32'h1234);

      // Reset in the middle of an op.
      op = OP_MULTU;
      a = 32'hFFFF_FFFF;
      b = 32'hFFFF_FFFF;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      chk("arst_busy", busy, 64'd0);
      chk("arst_done", done, 64'd0);
      chk("arst_hi", hi, 64'd0);
      chk("arst_lo", lo, 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("arst_nodone", done, 64'd0);
         chk("arst_idle", busy, 64'd0);
      end
      rst_n = 1'b1;
      run_op("post_rst", OP_MULT, 32'd3, 32'd4,
             32'd0, 32'hC, 5, 0, 0);

`ifdef XALU_FLUSH_EN
      op = OP_DIV;
      a = 32'd100;
      b = 32'd7;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      tick;
      chk("fl_busy4", busy, 64'd1);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("fl_idle", busy, 64'd0);
      chk("fl_nodone", done, 64'd0);
      chk("fl_hi", hi, m_hi);
      chk("fl_lo", lo, m_lo);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk("fl_quiet", done, 64'd0);
      end
      mov("fl_mtlo", 1'b0, 32'hABCD);
      flush = 1'b1;
      start = 1'b1;
      tick;
      flush = 1'b0;
      start = 1'b0;
      chk("fl_block", busy, 64'd0);
`endif

      chk("sb_empty", sb.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
